mc_ctrl: RTL

//   Multi-cycle control FSM that sequences the MIPS datapath around the ALU.

---
 rtl/mc_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM with memory handshakes, retire counter and timeout
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_ORI, C_LW, C_SW, C_LUI, C_BEQ, C_J, C_BAD
  } cls_t;

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  // Last wait count before giving up; only meaningful when MEM_TIMEOUT != 0.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  cls_t              cls_q, dec_cls;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout, entering_wait, wait_noack, retire;

  always_comb begin
    dec_cls = C_BAD;
    case (op)
      6'h00: if (func == 6'h20 || func == 6'h22) dec_cls = C_RTYPE;
      6'h0D: dec_cls = C_ORI;
      6'h23: dec_cls = C_LW;
      6'h2B: dec_cls = C_SW;
      6'h0F: dec_cls = C_LUI;
      6'h04: dec_cls = C_BEQ;
      6'h02: dec_cls = C_J;
      default: dec_cls = C_BAD;
    endcase
  end

  assign timeout = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    err        = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        // An ack arriving on the final allowed cycle still wins over the timeout.
        if (imem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        case (dec_cls)
          C_J: begin
            pc_we   = 1'b1;
            pc_src  = 2'd2;
            state_d = S_FETCH;
          end
          C_BAD:   state_d = S_ERR;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_BEQ: begin
            pc_we   = zero;
            pc_src  = 2'd1;
            state_d = S_FETCH;
          end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_SW);
        if (dmem_ack) state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
        else if (timeout) state_d = S_ERR;
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (cls_q == C_RTYPE);
        mem_to_reg = (cls_q == C_LW);
        state_d    = S_FETCH;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign entering_wait = (state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM);
  assign wait_noack    = (state_q == S_FETCH && !imem_ack) || (state_q == S_MEM && !dmem_ack);
  assign retire        = (state_d == S_FETCH) &&
                         (state_q == S_DECODE || state_q == S_EXEC ||
                          state_q == S_MEM    || state_q == S_WB);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_BAD;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= dec_cls;
      if (entering_wait) wait_q <= '0;
      else if (wait_noack) wait_q <= wait_q + 1'b1;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
